// File: rtl/srt4_pkg.sv
// Shared constants for the radix-4 SRT divider iteration engine: digit/state
// encodings, datapath widths and the quotient-digit selection thresholds.
package srt4_pkg;

    localparam int XLEN   = 32;
    localparam int WW     = 38;
    localparam int EST_W  = 7;
    localparam int DIDX_W = 3;

    localparam logic [2:0] DIG_P2 = 3'b010;
    localparam logic [2:0] DIG_P1 = 3'b001;
    localparam logic [2:0] DIG_Z  = 3'b000;
    localparam logic [2:0] DIG_M1 = 3'b101;
    localparam logic [2:0] DIG_M2 = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ITER = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_NORM,
        FSM_ITER,
        FSM_DONE
    } fsm_t;

    // Thresholds in units of 1/16, indexed by divisor bits [-2:-4].
    localparam logic signed [EST_W-1:0] M2 [8] = '{
        7'sd12, 7'sd14, 7'sd15, 7'sd16, 7'sd18, 7'sd20, 7'sd20, 7'sd24
    };
    localparam logic signed [EST_W-1:0] M1 [8] = '{
        7'sd4, 7'sd4, 7'sd4, 7'sd4, 7'sd6, 7'sd6, 7'sd8, 7'sd8
    };
    localparam logic signed [EST_W-1:0] M0 [8] = '{
        -7'sd4, -7'sd5, -7'sd6, -7'sd6, -7'sd6, -7'sd8, -7'sd8, -7'sd8
    };
    localparam logic signed [EST_W-1:0] MM1 [8] = '{
        -7'sd13, -7'sd15, -7'sd16, -7'sd18, -7'sd20, -7'sd20, -7'sd22, -7'sd24
    };

endpackage

// File: rtl/srt4_digit_generator_qds.sv
// Radix-4 quotient-digit selection: compares the truncated 4w estimate
// against the divisor-interval thresholds and returns the encoded digit.
module srt4_qds
    import srt4_pkg::*;
(
    input  logic [EST_W-1:0]  est,
    input  logic [DIDX_W-1:0] d_idx,
    output logic [2:0]        digit
);

    logic signed [EST_W-1:0] est_s;

    assign est_s = $signed(est);

    always_comb begin
        digit = DIG_Z;
        if (est_s >= M2[d_idx]) begin
            digit = DIG_P2;
        end else if (est_s >= M1[d_idx]) begin
            digit = DIG_P1;
        end else if (est_s >= M0[d_idx]) begin
            digit = DIG_Z;
        end else if (est_s >= MM1[d_idx]) begin
            digit = DIG_M1;
        end else begin
            digit = DIG_M2;
        end
    end

endmodule

// File: rtl/srt4_digit_generator.sv
// Iteration engine of the unsigned 32-bit radix-4 SRT divider: normalizes the
// divisor, runs the non-redundant remainder recurrence and emits one digit per cycle.
module srt4_digit_generator
    import srt4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    output logic             busy,
    output logic [2:0]       q_digit,
    output logic [1:0]       state_out,
    output logic             q_dec,
    output logic [XLEN-1:0]  remainder,
    output logic             div_by_zero
);

    fsm_t state, state_nx;

    logic [XLEN-1:0] x_r, d_r;
    logic [WW-1:0]   w_r, dn_r;
    logic [4:0]      s_r, cnt_r;
    logic            q_dec_r, dbz_r;
    logic [XLEN-1:0] rem_r;

    logic [4:0]        lz;
    logic [XLEN-1:0]   d_norm;
    logic [4:0]        n_digits;
    logic [WW-1:0]     w4, mult, w_next, wc;
    logic [EST_W-1:0]  est;
    logic [DIDX_W-1:0] d_idx;
    logic [2:0]        digit;
    logic [5:0]        rem_sh;
    logic [XLEN-1:0]   rem_calc;

    // Leading-zero count of the latched divisor; the highest set bit wins.
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < XLEN; i++) begin
            if (d_r[i]) lz = 5'(XLEN - 1 - i);
        end
    end

    assign d_norm   = d_r << lz;
    assign n_digits = {1'b0, lz[4:1]} + (lz[0] ? 5'd2 : 5'd1);

    assign w4    = w_r << 2;
    assign est   = w4[WW-1 -: EST_W];
    assign d_idx = dn_r[WW-5 -: DIDX_W];

    srt4_qds u_qds (
        .est   (est),
        .d_idx (d_idx),
        .digit (digit)
    );

    always_comb begin
        mult = '0;
        case (digit)
            DIG_P2:  mult = dn_r << 1;
            DIG_P1:  mult = dn_r;
            DIG_M1:  mult = -dn_r;
            DIG_M2:  mult = -(dn_r << 1);
            default: mult = '0;
        endcase
    end

    assign w_next = w4 - mult;

    // A negative final remainder is folded back by one divisor; the consumer
    // compensates the quotient through q_dec.
    assign wc       = w_next[WW-1] ? (w_next + dn_r) : w_next;
    assign rem_sh   = {1'b0, s_r} + 6'd3;
    assign rem_calc = XLEN'(wc >> rem_sh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FSM_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        state_out = ST_IDLE;
        q_digit   = DIG_Z;
        case (state)
            FSM_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = FSM_NORM;
            end
            FSM_NORM: begin
                state_nx = (d_r == '0) ? FSM_DONE : FSM_ITER;
            end
            FSM_ITER: begin
                state_out = ST_ITER;
                q_digit   = digit;
                if (cnt_r == 5'd0) state_nx = FSM_DONE;
            end
            FSM_DONE: begin
                state_out = ST_DONE;
                state_nx  = FSM_IDLE;
            end
            default: state_nx = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            d_r     <= '0;
            w_r     <= '0;
            dn_r    <= '0;
            s_r     <= '0;
            cnt_r   <= '0;
            q_dec_r <= 1'b0;
            dbz_r   <= 1'b0;
            rem_r   <= '0;
        end else begin
            case (state)
                FSM_IDLE: begin
                    if (start) begin
                        x_r     <= dividend;
                        d_r     <= divisor;
                        q_dec_r <= 1'b0;
                        dbz_r   <= 1'b0;
                        rem_r   <= '0;
                    end
                end
                FSM_NORM: begin
                    if (d_r == '0) begin
                        dbz_r   <= 1'b1;
                        rem_r   <= x_r;
                        q_dec_r <= 1'b0;
                    end else begin
                        dn_r  <= {3'b000, d_norm, 3'b000};
                        // w0 = X/8 for odd shifts, X/4 for even ones.
                        w_r   <= lz[0] ? {6'b0, x_r} : {5'b0, x_r, 1'b0};
                        s_r   <= lz;
                        cnt_r <= n_digits - 5'd1;
                    end
                end
                FSM_ITER: begin
                    w_r   <= w_next;
                    cnt_r <= cnt_r - 5'd1;
                    if (cnt_r == 5'd0) begin
                        q_dec_r <= w_next[WW-1];
                        rem_r   <= rem_calc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_dec       = q_dec_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_srt4_digit_generator.sv
// Self-checking bench for srt4_digit_generator: directed and random divisions
// checked against an arithmetic quotient/remainder model and digit-count rules.
module tb_srt4_digit_generator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic [2:0]  q_digit;
    logic [1:0]  state_out;
    logic        q_dec;
    logic [31:0] remainder;
    logic        div_by_zero;

    int tests;
    int fails;
    int qdec_cnt;

    // Expected entry: {dbz, n_digits[4:0], quotient[31:0], remainder[31:0]}
    logic [69:0] exp_q[$];

    srt4_digit_generator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .q_digit     (q_digit),
        .state_out   (state_out),
        .q_dec       (q_dec),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_n(input logic [31:0] d);
        int s;
        s = 0;
        if (d == 32'd0) return 0;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) break;
            s++;
        end
        return (s % 2 == 0) ? (s / 2 + 1) : ((s + 3) / 2);
    endfunction

    function automatic logic [69:0] pack(input logic dbz, input int n,
                                         input logic [31:0] q, input logic [31:0] r);
        return {dbz, 5'(n), q, r};
    endfunction

    function automatic logic [69:0] model(input logic [31:0] x, input logic [31:0] d);
        if (d == 32'd0) return pack(1'b1, 0, 32'd0, x);
        return pack(1'b0, model_n(d), x / d, x % d);
    endfunction

    // ---------------- driver ----------------
    task automatic run_div(input logic [31:0] x, input logic [31:0] d,
                           input logic [69:0] e, input int glitch);
        logic done;
        exp_q.push_back(e);
        @(negedge clk);
        dividend = x;
        divisor  = d;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done  = 1'b0;
        for (int k = 1; k < 40 && !done; k++) begin
            if (state_out == 2'b10) begin
                done = 1'b1;
            end else begin
                if (k == glitch) begin
                    start    = 1'b1;
                    dividend = 32'h0000_0007;
                    divisor  = 32'h8000_0000;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_reached", 64'(done), 64'd1);
        if (!done) exp_q.delete();
        @(negedge clk);
    endtask

    // ---------------- scoreboard / compare ----------------
    logic        busy_prev;
    logic        in_op;
    logic        hold_chk;
    int          cyc;
    int          ndig;
    longint      acc;
    int          dig;
    logic        dvalid;
    logic [69:0] e;
    logic [31:0] held_rem;
    logic        held_qdec;
    logic        held_dbz;

    initial begin
        busy_prev = 1'b0;
        in_op     = 1'b0;
        hold_chk  = 1'b0;
        cyc       = 0;
        ndig      = 0;
        acc       = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
            in_op     = 1'b0;
            hold_chk  = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                cyc   = 1;
                acc   = 0;
                ndig  = 0;
                in_op = 1'b1;
                check("clear_on_start", {31'd0, q_dec, div_by_zero, remainder}, 64'd0);
            end else if (busy) begin
                cyc++;
            end

            if (state_out == 2'b01) begin
                dvalid = 1'b1;
                case (q_digit)
                    3'b010:  dig = 2;
                    3'b001:  dig = 1;
                    3'b000:  dig = 0;
                    3'b101:  dig = -1;
                    3'b110:  dig = -2;
                    default: begin dig = 0; dvalid = 1'b0; end
                endcase
                check("digit_encoding", 64'(dvalid), 64'd1);
                if (ndig == 0) check("first_digit_nonneg", 64'(dig >= 0), 64'd1);
                acc = acc * 4 + longint'(dig);
                ndig++;
            end else begin
                check("digit_zero_outside_iter", 64'(q_digit), 64'd0);
            end

            if (state_out == 2'b10 && in_op) begin
                check("exp_available", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("latency", 64'(cyc), 64'(e[69] ? 2 : int'(e[68:64]) + 2));
                    check("digit_count", 64'(ndig), 64'(e[68:64]));
                    check("div_by_zero", 64'(div_by_zero), 64'(e[69]));
                    check("remainder", 64'(remainder), 64'(e[31:0]));
                    if (!e[69]) check("quotient", 64'(acc - longint'(q_dec)), 64'(e[63:32]));
                    else        check("dbz_q_dec", 64'(q_dec), 64'd0);
                end
                if (q_dec) qdec_cnt++;
                held_rem  = remainder;
                held_qdec = q_dec;
                held_dbz  = div_by_zero;
                hold_chk  = 1'b1;
                in_op     = 1'b0;
            end else if (hold_chk) begin
                check("idle_after_done", {61'd0, busy, state_out}, 64'd0);
                check("hold_outputs", {30'd0, held_qdec, held_dbz, held_rem},
                      {30'd0, q_dec, div_by_zero, remainder});
                hold_chk = 1'b0;
            end
            busy_prev = busy;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] x, d;
        int sel;
        tests    = 0;
        fails    = 0;
        qdec_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_state", {58'd0, busy, state_out, q_digit}, 64'd0);
        check("reset_dout", {31'd0, q_dec, div_by_zero, remainder}, 64'd0);
        rst_n = 1'b1;

        // Pin the model against hand-computed values.
        check("model_n_d7", 64'(model_n(32'd7)), 64'd16);
        check("model_n_d1", 64'(model_n(32'd1)), 64'd17);
        check("model_n_dmsb", 64'(model_n(32'h8000_0000)), 64'd1);
        check("model_n_d3", 64'(model_n(32'd3)), 64'd16);
        check("model_100_7", 64'(model(32'd100, 32'd7)), 64'(pack(1'b0, 16, 32'd14, 32'd2)));

        run_div(32'd100, 32'd7, pack(1'b0, 16, 32'd14, 32'd2), 0);
        run_div(32'hFFFF_FFFF, 32'd1, pack(1'b0, 17, 32'hFFFF_FFFF, 32'd0), 0);
        run_div(32'h8000_0000, 32'h8000_0000, pack(1'b0, 1, 32'd1, 32'd0), 0);
        run_div(32'd5, 32'd0, pack(1'b1, 0, 32'd0, 32'd5), 0);
        run_div(32'd1000, 32'd3, pack(1'b0, 16, 32'd333, 32'd1), 4);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, pack(1'b0, 1, 32'd1, 32'd0), 0);
        run_div(32'd6, 32'd7, pack(1'b0, 16, 32'd0, 32'd6), 0);

        // Reset in the middle of an iteration.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_iter", 64'(state_out), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_state", {58'd0, busy, state_out, q_digit}, 64'd0);
        check("abort_dout", {31'd0, q_dec, div_by_zero, remainder}, 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        run_div(32'd100, 32'd7, pack(1'b0, 16, 32'd14, 32'd2), 0);

        for (int i = 0; i < 1200; i++) begin
            sel = $urandom_range(0, 9);
            x   = $urandom;
            case (sel)
                0: d = 32'd1;
                1: d = x;
                2: begin
                    d = $urandom;
                    if (d == 32'd0) d = 32'd1;
                    x = x % d;
                end
                3, 4: d = $urandom;
                9: d = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                default: d = $urandom >> $urandom_range(0, 31);
            endcase
            if (sel != 9 && d == 32'd0) d = 32'd3;
            run_div(x, d, model(x, d), (i % 7 == 0) ? 3 : 0);
        end

        check("q_dec_seen", 64'(qdec_cnt > 0), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
